// File: rtl/dispatch_stage_if.sv
// dispatch_stage_if: decoded-instruction push bus from ID into the dispatch stage.
// The master (ID) drives the instruction and id_valid; the slave returns id_ready.
interface dispatch_stage_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
);
    logic              id_valid;
    logic              id_ready;
    logic [OP_W-1:0]   id_op;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc;
    logic [4:0]        id_rd;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_rs1_en;
    logic              id_rs2_en;
    logic              id_is_mem;
    logic              id_wr_rd;

    modport master (
        output id_valid, id_op, id_imm, id_pc, id_rd, id_rs1, id_rs2,
               id_rs1_en, id_rs2_en, id_is_mem, id_wr_rd,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_op, id_imm, id_pc, id_rd, id_rs1, id_rs2,
               id_rs1_en, id_rs2_en, id_is_mem, id_wr_rd,
        output id_ready
    );
endinterface

// File: rtl/dispatch_stage.sv
// dispatch_stage: buffers decoded instructions in a small FIFO and dispatches the
// head into the RS/LSB/ROB back end as a registered, one-cycle issue bundle.
// Operands come from the regfile, the ROB, a rename forward from the bundle
// currently being presented, and (optionally) the CDB.
// Optional feature: define DISPATCH_CDB_BYPASS_EN to snoop the CDB both at operand
// lookup and on the presented bundle.
module dispatch_stage #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int RS_W   = 4,
    parameter int DEPTH  = 4,
    parameter int OP_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    dispatch_stage_if.slave     id,
    input  logic                rf_rs1_busy,
    input  logic                rf_rs2_busy,
    input  logic [DATA_W-1:0]   rf_rs1_val,
    input  logic [DATA_W-1:0]   rf_rs2_val,
    output logic [ROB_W-1:0]    rob_q1_tag,
    output logic [ROB_W-1:0]    rob_q2_tag,
    input  logic                rob_q1_ready,
    input  logic                rob_q2_ready,
    input  logic [DATA_W-1:0]   rob_q1_val,
    input  logic [DATA_W-1:0]   rob_q2_val,
    input  logic [ROB_W-1:0]    rob_nxt_tag,
    input  logic [ROB_W:0]      rob_free,
    input  logic [RS_W-1:0]     rs_free,
    input  logic [RS_W-1:0]     lsb_free,
    input  logic                cdb_valid,
    input  logic [ROB_W-1:0]    cdb_tag,
    input  logic [DATA_W-1:0]   cdb_val,
    output logic                out_rs_valid,
    output logic                out_lsb_valid,
    output logic                out_rob_alloc,
    output logic                out_rename,
    output logic [OP_W-1:0]     out_op,
    output logic [DATA_W-1:0]   out_imm,
    output logic [DATA_W-1:0]   out_pc,
    output logic [4:0]          out_rd,
    output logic [ROB_W-1:0]    out_tag,
    output logic                out_qj,
    output logic                out_qk,
    output logic [DATA_W-1:0]   out_vj,
    output logic [DATA_W-1:0]   out_vk
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic              rs1_en;
        logic              rs2_en;
        logic              is_mem;
        logic              wr_rd;
    } entry_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [4:0]        rd;
        logic [ROB_W-1:0]  tag;
        logic              qj;
        logic              qk;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic              is_mem;
        logic              wr_rd;
    } bundle_t;

    typedef struct packed {
        logic              q;
        logic [DATA_W-1:0] v;
    } opnd_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             p_q, p_d;
    bundle_t          iss_q, iss_d;

    entry_t           head;
    entry_t           push_ent;
    logic             id_ready_int;
    logic             push;
    logic             fire;
    logic             same_tgt;
    logic [RS_W-1:0]  tgt_free;
    logic             fwd_ok;
    opnd_t            opj, opk;

    // Priority-ordered operand lookup for one source of the FIFO head.
    function automatic opnd_t resolve(
        input logic              en,
        input logic [4:0]        idx,
        input logic              fwd_hit,
        input logic [ROB_W-1:0]  fwd_tag,
        input logic              busy,
        input logic [DATA_W-1:0] rf_val,
        input logic              rob_rdy,
        input logic [DATA_W-1:0] rob_val
    );
        opnd_t r;
        r.q = 1'b0;
        r.v = '0;
        if (en && idx != 5'd0) begin
            if (fwd_hit) begin
                r.q = 1'b1;
                r.v = DATA_W'(fwd_tag);
            end else if (!busy) begin
                r.v = rf_val;
            end else if (rob_rdy) begin
                r.v = rob_val;
`ifdef DISPATCH_CDB_BYPASS_EN
            end else if (cdb_valid && cdb_tag == rf_val[ROB_W-1:0]) begin
                r.v = cdb_val;
`endif
            end else begin
                r.q = 1'b1;
                r.v = DATA_W'(rf_val[ROB_W-1:0]);
            end
        end
        return r;
    endfunction

    assign rob_q1_tag  = rf_rs1_val[ROB_W-1:0];
    assign rob_q2_tag  = rf_rs2_val[ROB_W-1:0];
    assign id.id_ready = id_ready_int;

    // Handshake, dispatch eligibility and operand lookup for the head entry.
    always_comb begin
        head                = mem_q[rd_ptr_q];
        push_ent.op         = id.id_op;
        push_ent.imm        = id.id_imm;
        push_ent.pc         = id.id_pc;
        push_ent.rd         = id.id_rd;
        push_ent.rs1        = id.id_rs1;
        push_ent.rs2        = id.id_rs2;
        push_ent.rs1_en     = id.id_rs1_en;
        push_ent.rs2_en     = id.id_rs2_en;
        push_ent.is_mem     = id.id_is_mem;
        push_ent.wr_rd      = id.id_wr_rd;
        // Full is judged on the registered count only, so ID never waits on the back end combinationally.
        id_ready_int        = (cnt_q < CNT_W'(DEPTH)) && rdy && !flush && !rst;
        push                = id.id_valid && id_ready_int;
        same_tgt            = p_q && (iss_q.is_mem == head.is_mem);
        tgt_free            = head.is_mem ? lsb_free : rs_free;
        fire                = (cnt_q != '0) && rdy && !flush && !rst
                              && (rob_free > (ROB_W+1)'(p_q))
                              && (tgt_free > RS_W'(same_tgt));
        fwd_ok              = p_q && iss_q.wr_rd && (iss_q.rd != 5'd0);
        opj = resolve(head.rs1_en, head.rs1, fwd_ok && (iss_q.rd == head.rs1), iss_q.tag,
                      rf_rs1_busy, rf_rs1_val, rob_q1_ready, rob_q1_val);
        opk = resolve(head.rs2_en, head.rs2, fwd_ok && (iss_q.rd == head.rs2), iss_q.tag,
                      rf_rs2_busy, rf_rs2_val, rob_q2_ready, rob_q2_val);
    end

    // Next FIFO and issue-register state; rdy low holds everything except flush.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        iss_d    = iss_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            p_d      = 1'b0;
        end else if (rdy) begin
            if (push) begin
                mem_d[wr_ptr_q] = push_ent;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (fire) begin
                rd_ptr_d     = rd_ptr_q + PTR_W'(1);
                iss_d.op     = head.op;
                iss_d.imm    = head.imm;
                iss_d.pc     = head.pc;
                iss_d.rd     = head.rd;
                // A bundle still being presented will take rob_nxt_tag, so the head takes the next one.
                iss_d.tag    = rob_nxt_tag + ROB_W'(p_q);
                iss_d.qj     = opj.q;
                iss_d.vj     = opj.v;
                iss_d.qk     = opk.q;
                iss_d.vk     = opk.v;
                iss_d.is_mem = head.is_mem;
                iss_d.wr_rd  = head.wr_rd;
            end
            p_d   = fire;
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(fire);
        end
    end

    // Control state and issue register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            p_q      <= 1'b0;
            iss_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            iss_q    <= iss_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Issue strobes and bundle; CDB can still resolve a pending operand while presenting.
    always_comb begin
        logic              live;
        logic              qj, qk;
        logic [DATA_W-1:0] vj, vk;
        live = p_q && rdy && !rst;
        qj   = iss_q.qj;
        qk   = iss_q.qk;
        vj   = iss_q.vj;
        vk   = iss_q.vk;
`ifdef DISPATCH_CDB_BYPASS_EN
        if (qj && cdb_valid && cdb_tag == iss_q.vj[ROB_W-1:0]) begin
            qj = 1'b0;
            vj = cdb_val;
        end
        if (qk && cdb_valid && cdb_tag == iss_q.vk[ROB_W-1:0]) begin
            qk = 1'b0;
            vk = cdb_val;
        end
`endif
        out_rs_valid  = live && !iss_q.is_mem;
        out_lsb_valid = live && iss_q.is_mem;
        out_rob_alloc = live;
        out_rename    = live && iss_q.wr_rd && (iss_q.rd != 5'd0);
        out_op        = rst ? '0 : iss_q.op;
        out_imm       = rst ? '0 : iss_q.imm;
        out_pc        = rst ? '0 : iss_q.pc;
        out_rd        = rst ? '0 : iss_q.rd;
        out_tag       = rst ? '0 : iss_q.tag;
        out_qj        = rst ? 1'b0 : qj;
        out_qk        = rst ? 1'b0 : qk;
        out_vj        = rst ? '0 : vj;
        out_vk        = rst ? '0 : vk;
    end

`ifndef DISPATCH_CDB_BYPASS_EN
    logic cdb_unused;
    assign cdb_unused = ^{cdb_valid, cdb_tag, cdb_val};
`endif
endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed sequences, an operand-resolution vector table and a
// randomized run against a queue-based reference model of the dispatch stage.
`timescale 1ns/1ps
module tb_dispatch_stage;
    localparam int DATA_W = 32;
    localparam int ROB_W  = 4;
    localparam int RS_W   = 4;
    localparam int DEPTH  = 4;
    localparam int OP_W   = 6;

    logic              clk;
    logic              rst, rdy, flush;
    logic              rf_rs1_busy, rf_rs2_busy;
    logic [31:0]       rf_rs1_val, rf_rs2_val;
    logic [3:0]        rob_q1_tag, rob_q2_tag;
    logic              rob_q1_ready, rob_q2_ready;
    logic [31:0]       rob_q1_val, rob_q2_val;
    logic [3:0]        rob_nxt_tag;
    logic [4:0]        rob_free;
    logic [3:0]        rs_free, lsb_free;
    logic              cdb_valid;
    logic [3:0]        cdb_tag;
    logic [31:0]       cdb_val;
    logic              out_rs_valid, out_lsb_valid, out_rob_alloc, out_rename;
    logic [5:0]        out_op;
    logic [31:0]       out_imm, out_pc;
    logic [4:0]        out_rd;
    logic [3:0]        out_tag;
    logic              out_qj, out_qk;
    logic [31:0]       out_vj, out_vk;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dispatch_stage_if #(.DATA_W(DATA_W), .OP_W(OP_W)) id_if ();

    dispatch_stage #(.DATA_W(DATA_W), .ROB_W(ROB_W), .RS_W(RS_W), .DEPTH(DEPTH), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .id(id_if),
        .rf_rs1_busy(rf_rs1_busy), .rf_rs2_busy(rf_rs2_busy),
        .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
        .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
        .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
        .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
        .rob_nxt_tag(rob_nxt_tag), .rob_free(rob_free),
        .rs_free(rs_free), .lsb_free(lsb_free),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .out_rs_valid(out_rs_valid), .out_lsb_valid(out_lsb_valid),
        .out_rob_alloc(out_rob_alloc), .out_rename(out_rename),
        .out_op(out_op), .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd), .out_tag(out_tag),
        .out_qj(out_qj), .out_qk(out_qk), .out_vj(out_vj), .out_vk(out_vk)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic defaults();
        rdy = 1'b1; flush = 1'b0;
        rf_rs1_busy = 1'b0; rf_rs2_busy = 1'b0; rf_rs1_val = '0; rf_rs2_val = '0;
        rob_q1_ready = 1'b0; rob_q2_ready = 1'b0; rob_q1_val = '0; rob_q2_val = '0;
        rob_nxt_tag = '0; rob_free = 5'd16; rs_free = 4'd4; lsb_free = 4'd4;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;
        id_if.id_valid = 1'b0;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic e1, input logic e2,
                             input logic is_mem, input logic wr_rd);
        id_if.id_valid  = 1'b1;
        id_if.id_op     = op;
        id_if.id_imm    = {26'd0, op} + 32'h100;
        id_if.id_pc     = {26'd0, op} << 2;
        id_if.id_rd     = rd;
        id_if.id_rs1    = rs1;
        id_if.id_rs2    = rs2;
        id_if.id_rs1_en = e1;
        id_if.id_rs2_en = e2;
        id_if.id_is_mem = is_mem;
        id_if.id_wr_rd  = wr_rd;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_rs"}, out_rs_valid, 0);
        chk({name, "_lsb"}, out_lsb_valid, 0);
        chk({name, "_alloc"}, out_rob_alloc, 0);
    endtask

    // Operand-resolution vectors for rs1; rs2 is left disabled in every vector.
    typedef struct {
        bit        en;
        bit [4:0]  idx;
        bit        busy;
        bit [31:0] rfv;
        bit        rrdy;
        bit [31:0] rv;
        bit        cv;
        bit [3:0]  ct;
        bit [31:0] cval;
        bit        q_byp;
        bit [31:0] v_byp;
        bit        q_nb;
        bit [31:0] v_nb;
    } vec_t;

    // Reference model state: FIFO as a queue, presented bundle as a record.
    typedef struct {
        bit [5:0]  op;
        bit [31:0] imm, pc;
        bit [4:0]  rd, rs1, rs2;
        bit        e1, e2, is_mem, wr_rd;
    } m_ent_t;

    typedef struct {
        bit [5:0]  op;
        bit [31:0] imm, pc;
        bit [4:0]  rd;
        bit [3:0]  tag;
        bit        qj, qk;
        bit [31:0] vj, vk;
        bit        is_mem, wr_rd;
    } m_iss_t;

    m_ent_t mq[$];
    bit     m_p;
    m_iss_t m_iss;

    function automatic void m_resolve(input bit en, input bit [4:0] idx, input bit busy,
                                      input bit [31:0] rfv, input bit rrdy, input bit [31:0] rv,
                                      output bit q, output bit [31:0] v);
        q = 1'b0;
        v = '0;
        if (!en || idx == 0) begin
            q = 1'b0;
        end else if (m_p && m_iss.wr_rd && m_iss.rd != 0 && m_iss.rd == idx) begin
            q = 1'b1;
            v = {28'd0, m_iss.tag};
        end else if (!busy) begin
            v = rfv;
        end else if (rrdy) begin
            v = rv;
`ifdef DISPATCH_CDB_BYPASS_EN
        end else if (cdb_valid && cdb_tag == rfv[3:0]) begin
            v = cdb_val;
`endif
        end else begin
            q = 1'b1;
            v = {28'd0, rfv[3:0]};
        end
    endfunction

    initial begin
        vec_t vt[7];
        vt[0] = '{1'b0, 5'd3, 1'b1, 32'h2,         1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 32'h0,    1'b0, 32'h0};
        vt[1] = '{1'b1, 5'd0, 1'b0, 32'd99,        1'b0, 32'h0,   1'b0, 4'd0, 32'h0,  1'b0, 32'h0,    1'b0, 32'h0};
        vt[2] = '{1'b1, 5'd5, 1'b0, 32'h1234,      1'b1, 32'hBAD, 1'b0, 4'd0, 32'h0,  1'b0, 32'h1234, 1'b0, 32'h1234};
        vt[3] = '{1'b1, 5'd5, 1'b1, 32'h9,         1'b1, 32'hAB,  1'b0, 4'd0, 32'h0,  1'b0, 32'hAB,   1'b0, 32'hAB};
        vt[4] = '{1'b1, 5'd6, 1'b1, 32'h2,         1'b0, 32'h0,   1'b1, 4'd2, 32'h55, 1'b0, 32'h55,   1'b1, 32'h2};
        vt[5] = '{1'b1, 5'd7, 1'b1, 32'hFFFF_FFF6, 1'b0, 32'h0,   1'b1, 4'd7, 32'h99, 1'b1, 32'h6,    1'b1, 32'h6};
        vt[6] = '{1'b1, 5'd9, 1'b1, 32'h4,         1'b1, 32'h77,  1'b1, 4'd4, 32'h55, 1'b0, 32'h77,   1'b0, 32'h77};

        defaults();
        set_instr(6'd1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        // Reset held for three edges with a push pending.
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_id_ready", id_if.id_ready, 0);
            chk("rst_rename", out_rename, 0);
            chk("rst_tag", out_tag, 0);
            chk_quiet("rst");
            next_cycle();
        end
        rst = 1'b0;
        id_if.id_valid = 1'b0;

        // Basic ADD: 2-cycle latency, values from the regfile.
        rf_rs1_val = 32'd5; rf_rs2_val = 32'd7; rob_nxt_tag = 4'd3;
        set_instr(6'd1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        chk("A_id_ready", id_if.id_ready, 1);
        next_cycle(); id_if.id_valid = 1'b0; settle();
        chk_quiet("A_lat1");
        next_cycle(); settle();
        chk("A_rs_valid", out_rs_valid, 1);
        chk("A_lsb_valid", out_lsb_valid, 0);
        chk("A_alloc", out_rob_alloc, 1);
        chk("A_tag", out_tag, 3);
        chk("A_qj", out_qj, 0);
        chk("A_qk", out_qk, 0);
        chk("A_vj", out_vj, 5);
        chk("A_vk", out_vk, 7);
        chk("A_rename", out_rename, 1);
        chk("A_rd", out_rd, 3);
        next_cycle(); settle();
        chk_quiet("A_clear");

        // Back-to-back: ADDI x4 then ADD reading x4 gets the forwarded tag.
        rob_nxt_tag = 4'd6; rf_rs1_val = 32'h11; rf_rs2_val = 32'h22;
        set_instr(6'd2, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle();
        set_instr(6'd1, 5'd5, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        next_cycle(); id_if.id_valid = 1'b0; settle();
        chk("B_first_tag", out_tag, 6);
        chk("B_first_qj", out_qj, 0);
        chk("B_first_vj", out_vj, 0);
        next_cycle(); settle();
        chk("B_second_valid", out_rs_valid, 1);
        chk("B_second_tag", out_tag, 7);
        chk("B_second_qj", out_qj, 1);
        chk("B_second_vj", out_vj, 6);
        next_cycle(); settle();
        chk_quiet("B_clear");

        // Operand-resolution table.
        for (int i = 0; i < 7; i++) begin
            defaults();
            rf_rs1_busy = vt[i].busy; rf_rs1_val = vt[i].rfv;
            rob_q1_ready = vt[i].rrdy; rob_q1_val = vt[i].rv;
            cdb_valid = vt[i].cv; cdb_tag = vt[i].ct; cdb_val = vt[i].cval;
            rf_rs2_busy = 1'b1; rf_rs2_val = 32'h3;
            set_instr(6'd7, 5'd0, vt[i].idx, 5'd3, vt[i].en, 1'b0, 1'b0, 1'b1);
            next_cycle(); id_if.id_valid = 1'b0; settle();
            chk($sformatf("T%0d_q1_tag", i), rob_q1_tag, vt[i].rfv[3:0]);
            next_cycle(); settle();
            chk($sformatf("T%0d_valid", i), out_rs_valid, 1);
`ifdef DISPATCH_CDB_BYPASS_EN
            chk($sformatf("T%0d_qj", i), out_qj, vt[i].q_byp);
            chk($sformatf("T%0d_vj", i), out_vj, vt[i].v_byp);
`else
            chk($sformatf("T%0d_qj", i), out_qj, vt[i].q_nb);
            chk($sformatf("T%0d_vj", i), out_vj, vt[i].v_nb);
`endif
            chk($sformatf("T%0d_qk", i), out_qk, 0);
            chk($sformatf("T%0d_vk", i), out_vk, 0);
            chk($sformatf("T%0d_rename", i), out_rename, 0);
            next_cycle();
        end
        defaults();
        next_cycle();

        // FIFO full with the RS full, then drain at one per cycle.
        rs_free = 4'd0;
        for (int i = 0; i < 4; i++) begin
            set_instr(6'(10 + i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            settle();
            chk($sformatf("D_ready%0d", i), id_if.id_ready, 1);
            next_cycle();
        end
        settle();
        chk("D_full", id_if.id_ready, 0);
        chk_quiet("D_full");
        next_cycle();
        rs_free = 4'd2; settle();
        chk("D_full_pop", id_if.id_ready, 0);
        next_cycle(); id_if.id_valid = 1'b0; settle();
        chk("D_ready_back", id_if.id_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("D_pop%0d", i), out_rs_valid, 1);
            chk($sformatf("D_pop_op%0d", i), out_op, 10 + i);
            next_cycle(); settle();
        end
        chk_quiet("D_drained");
        defaults();
        next_cycle();

        // SW then LW with one LSB slot: LW waits for lsb_free; then BEQ.
        lsb_free = 4'd1;
        set_instr(6'd20, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
        set_instr(6'd21, 5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        next_cycle(); id_if.id_valid = 1'b0; lsb_free = 4'd0; settle();
        chk("E_sw_lsb", out_lsb_valid, 1);
        chk("E_sw_rs", out_rs_valid, 0);
        chk("E_sw_rename", out_rename, 0);
        next_cycle(); settle();
        chk("E_lw_hold1", out_lsb_valid, 0);
        next_cycle(); lsb_free = 4'd1; settle();
        chk("E_lw_hold2", out_lsb_valid, 0);
        next_cycle(); settle();
        chk("E_lw_lsb", out_lsb_valid, 1);
        chk("E_lw_rd", out_rd, 8);
        chk("E_lw_rename", out_rename, 1);
        next_cycle();
        set_instr(6'd30, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle(); id_if.id_valid = 1'b0;
        next_cycle(); settle();
        chk("E_beq_rs", out_rs_valid, 1);
        chk("E_beq_rename", out_rename, 0);
        next_cycle();

        // Flush with three queued entries.
        rs_free = 4'd0;
        for (int i = 0; i < 3; i++) begin
            set_instr(6'(40 + i), 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            next_cycle();
        end
        flush = 1'b1; settle();
        chk("F_ready_in_flush", id_if.id_ready, 0);
        next_cycle(); flush = 1'b0; rs_free = 4'd4; id_if.id_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_quiet($sformatf("F_post%0d", i));
            next_cycle();
        end
        set_instr(6'd50, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("F_ready_new", id_if.id_ready, 1);
        next_cycle(); id_if.id_valid = 1'b0; settle();
        chk_quiet("F_new_lat1");
        next_cycle(); settle();
        chk("F_new_valid", out_rs_valid, 1);
        chk("F_new_op", out_op, 50);
        next_cycle();

        // rdy low during presentation: strobes drop and the bundle comes back unchanged.
        rob_nxt_tag = 4'd9;
        set_instr(6'd60, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle(); id_if.id_valid = 1'b0;
        next_cycle(); rdy = 1'b0; rob_nxt_tag = 4'd12; settle();
        chk_quiet("G_rdy_low");
        chk("G_rdy_low_rename", out_rename, 0);
        chk("G_rdy_low_ready", id_if.id_ready, 0);
        next_cycle(); rdy = 1'b1; settle();
        chk("G_represent", out_rs_valid, 1);
        chk("G_tag", out_tag, 9);
        next_cycle(); settle();
        chk_quiet("G_clear");

        // Randomized run against the queue model.
        defaults();
        rst = 1'b1;
        next_cycle(); next_cycle();
        rst = 1'b0;
        mq.delete();
        m_p = 1'b0;
        m_iss = '{default: '0};
        for (int c = 0; c < 3000; c++) begin
            bit        e_ready, fire, same, eqj, eqk;
            bit [31:0] evj, evk;
            int        tfree;
            m_ent_t    h, n;
            bit        nq1, nq2;
            bit [31:0] nv1, nv2;

            rdy          = ($urandom_range(0, 7) != 0);
            flush        = rdy && ($urandom_range(0, 39) == 0);
            rob_free     = 5'($urandom_range(0, 16));
            rs_free      = 4'($urandom_range(0, 3));
            lsb_free     = 4'($urandom_range(0, 3));
            rob_nxt_tag  = 4'($urandom);
            rf_rs1_busy  = $urandom_range(0, 1) == 1;
            rf_rs2_busy  = $urandom_range(0, 1) == 1;
            rf_rs1_val   = $urandom;
            rf_rs2_val   = $urandom;
            rob_q1_ready = $urandom_range(0, 2) == 0;
            rob_q2_ready = $urandom_range(0, 2) == 0;
            rob_q1_val   = $urandom;
            rob_q2_val   = $urandom;
            cdb_valid    = $urandom_range(0, 1) == 1;
            cdb_tag      = ($urandom_range(0, 1) == 1) ? rf_rs1_val[3:0] : 4'($urandom);
            cdb_val      = $urandom;
            id_if.id_valid  = $urandom_range(0, 1) == 1;
            id_if.id_op     = 6'($urandom);
            id_if.id_imm    = $urandom;
            id_if.id_pc     = $urandom;
            id_if.id_rd     = 5'($urandom_range(0, 7));
            id_if.id_rs1    = 5'($urandom_range(0, 7));
            id_if.id_rs2    = 5'($urandom_range(0, 7));
            id_if.id_rs1_en = $urandom_range(0, 3) != 0;
            id_if.id_rs2_en = $urandom_range(0, 3) != 0;
            id_if.id_is_mem = $urandom_range(0, 2) == 0;
            id_if.id_wr_rd  = $urandom_range(0, 3) != 0;

            e_ready = (mq.size() < DEPTH) && rdy && !flush;
            eqj = m_iss.qj; evj = m_iss.vj; eqk = m_iss.qk; evk = m_iss.vk;
`ifdef DISPATCH_CDB_BYPASS_EN
            if (eqj && cdb_valid && cdb_tag == evj[3:0]) begin eqj = 1'b0; evj = cdb_val; end
            if (eqk && cdb_valid && cdb_tag == evk[3:0]) begin eqk = 1'b0; evk = cdb_val; end
`endif
            settle();
            chk("R_id_ready", id_if.id_ready, e_ready);
            chk("R_rs_valid", out_rs_valid, m_p && rdy && !m_iss.is_mem);
            chk("R_lsb_valid", out_lsb_valid, m_p && rdy && m_iss.is_mem);
            chk("R_alloc", out_rob_alloc, m_p && rdy);
            chk("R_rename", out_rename, m_p && rdy && m_iss.wr_rd && m_iss.rd != 0);
            chk("R_q2_tag", rob_q2_tag, rf_rs2_val[3:0]);
            if (m_p && rdy) begin
                chk("R_tag", out_tag, m_iss.tag);
                chk("R_op", out_op, m_iss.op);
                chk("R_rd", out_rd, m_iss.rd);
                chk("R_imm", out_imm, m_iss.imm);
                chk("R_pc", out_pc, m_iss.pc);
                chk("R_qj", out_qj, eqj);
                chk("R_vj", out_vj, evj);
                chk("R_qk", out_qk, eqk);
                chk("R_vk", out_vk, evk);
            end

            if (flush) begin
                mq.delete();
                m_p = 1'b0;
            end else if (rdy) begin
                fire = 1'b0;
                if (mq.size() > 0) begin
                    h = mq[0];
                    same = m_p && (m_iss.is_mem == h.is_mem);
                    tfree = h.is_mem ? int'(lsb_free) : int'(rs_free);
                    fire = (int'(rob_free) > int'(m_p)) && (tfree > int'(same));
                end
                if (fire) begin
                    m_resolve(h.e1, h.rs1, rf_rs1_busy, rf_rs1_val, rob_q1_ready, rob_q1_val, nq1, nv1);
                    m_resolve(h.e2, h.rs2, rf_rs2_busy, rf_rs2_val, rob_q2_ready, rob_q2_val, nq2, nv2);
                    m_iss.tag    = 4'(rob_nxt_tag + 4'(m_p));
                    m_iss.op     = h.op;
                    m_iss.imm    = h.imm;
                    m_iss.pc     = h.pc;
                    m_iss.rd     = h.rd;
                    m_iss.is_mem = h.is_mem;
                    m_iss.wr_rd  = h.wr_rd;
                    m_iss.qj = nq1; m_iss.vj = nv1;
                    m_iss.qk = nq2; m_iss.vk = nv2;
                    void'(mq.pop_front());
                end
                m_p = fire;
                if (id_if.id_valid && e_ready) begin
                    n.op = id_if.id_op; n.imm = id_if.id_imm; n.pc = id_if.id_pc;
                    n.rd = id_if.id_rd; n.rs1 = id_if.id_rs1; n.rs2 = id_if.id_rs2;
                    n.e1 = id_if.id_rs1_en; n.e2 = id_if.id_rs2_en;
                    n.is_mem = id_if.id_is_mem; n.wr_rd = id_if.id_wr_rd;
                    mq.push_back(n);
                end
            end
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
